spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//   SPI peripheral (slave) endpoint for the SS/SCLK/MOSI/MISO bus driven by the team's SPI master.
//   Oversamples the bus in the CLOCK domain. Receives N-bit words on MOSI into DATAO.
//   Returns a host-preloaded N-bit word on MISO. Host side uses the same DATAI/WR/BUSY/DATAO/VALID
//   handshake as the UART, so either link can sit behind the same controller.
// PARAMETERS
//   N     8  word width in bits, MSB first on both MOSI and MISO
//   CPOL  0  SCLK idle level
//   CPHA  0  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
// PORTS
//   CLOCK    in   1  system clock; SCLK must be <= CLOCK/8
//   RESET_N  in   1  asynchronous, active-low reset
//   SS       in   1  slave select, active low, asynchronous to CLOCK
//   SCLK     in   1  serial clock from master, asynchronous to CLOCK
//   MOSI     in   1  serial data from master
//   MISO     out  1  serial data to master
//   DATAI    in   N  word to return on MISO in the next word slot
//   WR       in   1  load DATAI into TX buffer; accepted only while BUSY=0
//   BUSY     out  1  TX buffer holds a word not yet moved into the shift register
//   DATAO    out  N  last complete received word; held until next word completes
//   VALID    out  1  one-CLOCK pulse when DATAO is updated
// BEHAVIOUR
//   Reset: DATAO=0, VALID=0, BUSY=0, MISO=0, state IDLE, TX buffer empty.
//     Synchronisers reset to idle values: SS=1, SCLK=CPOL.
//   Sync: SS, SCLK and MOSI each pass a 2-flop synchroniser; edges are detected from stages 2/3.
//     An internal sample/shift event happens 3 CLOCK cycles after the pin edge.
//   Edges: leading = SCLK leaves CPOL; trailing = SCLK returns to CPOL.
//     Sample edge = leading when CPHA=0, trailing when CPHA=1; shift edge = the other edge.
//   Host side: WR=1 with BUSY=0 latches DATAI; BUSY=1 from the next cycle.
//     WR while BUSY=1 is ignored, and the buffer is unchanged.
//     BUSY clears in the cycle the buffer is copied into the TX shift register.
//   FSM IDLE:
//     MISO=0, bit counter=0.
//     SS falling -> SHIFT. Load TX shift register from the buffer if BUSY=1, else all zeros.
//   FSM SHIFT:
//     MISO = TX shift register MSB.
//     Sample edge: shift the synchronised MOSI into the RX register LSB; bit counter +1.
//     Shift edge: TX register shifts left by one. When CPHA=1, the first shift edge of each word
//       does not shift, so that edge presents the MSB.
//     Nth sample edge (counter wraps to 0):
//       - DATAO <= assembled word; VALID=1 on the following cycle only.
//       - TX register reloads (buffer if BUSY=1, else zeros), allowing back-to-back words with SS held low.
//       - Stay in SHIFT.
//     SS rising (any bit count) -> IDLE. A partial word is discarded, no VALID, DATAO unchanged.
//       The TX buffer is kept if not yet consumed.
//   Simultaneous WR and buffer consumption in the same cycle:
//     - Consumption wins; WR is ignored because BUSY was 1 that cycle.
//   SCLK edges while SS high are ignored. RESET_N low mid-frame aborts immediately to the reset state.
// TESTING
//   1 Mode 0: WR DATAI=0x3C, then master frame MOSI=0xA5
//     -> DATAO=0xA5 with a single VALID pulse; master reads 0x3C; BUSY 1->0 at SS fall.
//   2 No preload: master frame MOSI=0x81 -> master reads 0x00; DATAO=0x81, VALID once.
//   3 Back-to-back with SS held low: WR 0x12, first word starts, WR 0x34 (accepted once BUSY=0),
//     MOSI 0x55,0xAA -> master reads 0x12,0x34; two VALID pulses with DATAO 0x55 then 0xAA.
//   4 Abort: SS raised after 3 bits -> no VALID, DATAO unchanged; next full frame 0x5A -> DATAO=0x5A.
//   5 WR 0x11, then WR 0x22 while BUSY=1 -> master reads 0x11; 0x22 never appears.
//   6 CPHA=1/CPOL=1 build, WR 0xC3, MOSI 0x96 -> DATAO=0x96, master reads 0xC3;
//     RESET_N pulse mid-frame -> all outputs at reset values, no VALID.

Source files
------------

// File: rtl/spi_slave_if.sv
// Bus bundle between an SPI master and spi_slave: SS/SCLK/MOSI/MISO pins plus host-side DATAI/WR/BUSY/DATAO/VALID.
// The slave modport is the peripheral's view; the master modport drives pins and host strobes.
interface spi_slave_if #(
  parameter int N = 8
);
  logic         SS;
  logic         SCLK;
  logic         MOSI;
  logic         MISO;
  logic [N-1:0] DATAI;
  logic         WR;
  logic         BUSY;
  logic [N-1:0] DATAO;
  logic         VALID;

  modport slave (
    input  SS, SCLK, MOSI, DATAI, WR,
    output MISO, BUSY, DATAO, VALID
  );

  modport master (
    output SS, SCLK, MOSI, DATAI, WR,
    input  MISO, BUSY, DATAO, VALID
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave oversampled in CLOCK: 2-flop pin sync, sample/shift act 3 CLOCKs after the pin edge; VALID pulses once per word.
// Host backpressure via BUSY: one-deep TX buffer, WR ignored while BUSY=1; no backpressure on the serial side.
module spi_slave #(
  parameter int N    = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  spi_slave_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t       state_q,     state_d;
  logic [2:0]   ss_sync_q,   ss_sync_d;
  logic [2:0]   sclk_sync_q, sclk_sync_d;
  logic [1:0]   mosi_sync_q, mosi_sync_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [N-1:0] rx_q,        rx_d;
  logic [N-1:0] tx_q,        tx_d;
  logic [N-1:0] buf_q,       buf_d;
  logic         busy_q,      busy_d;
  logic [N-1:0] datao_q,     datao_d;
  logic         valid_q,     valid_d;
  logic         skip_q,      skip_d;

  logic         ss_fall;
  logic         ss_rise;
  logic         lead_evt;
  logic         trail_evt;
  logic         sample_evt;
  logic         shift_evt;
  logic [N-1:0] rx_next;
  logic [N-1:0] tx_fill;

  // Edges come from synchroniser stages 2 and 3 (bits 1 and 2).
  assign ss_fall    = ~ss_sync_q[1] &  ss_sync_q[2];
  assign ss_rise    =  ss_sync_q[1] & ~ss_sync_q[2];
  assign lead_evt   = (sclk_sync_q[1] != CPOL) && (sclk_sync_q[2] == CPOL);
  assign trail_evt  = (sclk_sync_q[1] == CPOL) && (sclk_sync_q[2] != CPOL);
  assign sample_evt = CPHA ? trail_evt : lead_evt;
  assign shift_evt  = CPHA ? lead_evt  : trail_evt;
  assign rx_next    = {rx_q[N-2:0], mosi_sync_q[1]};
  assign tx_fill    = busy_q ? buf_q : '0;

  always_comb begin
    state_d     = state_q;
    ss_sync_d   = {ss_sync_q[1:0], bus.SS};
    sclk_sync_d = {sclk_sync_q[1:0], bus.SCLK};
    mosi_sync_d = {mosi_sync_q[0], bus.MOSI};
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    buf_d       = buf_q;
    busy_d      = busy_q;
    datao_d     = datao_q;
    valid_d     = 1'b0;
    skip_d      = skip_q;

    if (bus.WR && !busy_q) begin
      buf_d  = bus.DATAI;
      busy_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        skip_d = CPHA;
        if (ss_fall) begin
          state_d = SHIFT;
          tx_d    = tx_fill;
          if (busy_q) busy_d = 1'b0;
        end
      end

      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sample_evt) begin
          rx_d = rx_next;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            datao_d = rx_next;
            valid_d = 1'b1;
            tx_d    = tx_fill;
            // The next shift edge belongs to the word just finished (CPHA=0) or must present the new MSB (CPHA=1).
            skip_d  = 1'b1;
            if (busy_q) busy_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (shift_evt) begin
          if (skip_q) skip_d = 1'b0;
          else        tx_d   = {tx_q[N-2:0], 1'b0};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= {3{CPOL}};
      mosi_sync_q <= 2'b00;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      datao_q     <= '0;
      valid_q     <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      datao_q     <= datao_d;
      valid_q     <= valid_d;
      skip_q      <= skip_d;
    end
  end

  assign bus.MISO  = (state_q == SHIFT) ? tx_q[N-1] : 1'b0;
  assign bus.BUSY  = busy_q;
  assign bus.DATAO = datao_q;
  assign bus.VALID = valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: mode-0 and mode-3 instances share SCLK phase and MOSI; each has its own SS and host side.
// Directed table, hand sequences (back-to-back, abort, busy-write, reset) and random frames vs a word-level model.
module tb_spi_slave;
  localparam int N = 8;
  localparam int H = 8;   // SCLK half period in CLOCK cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p = 1'b0;
  logic       mosi = 1'b0;
  logic       ss [2];
  logic       wr [2];
  logic [7:0] di [2];

  always #5 clk = ~clk;

  spi_slave_if #(.N(N)) ifc0 ();
  spi_slave_if #(.N(N)) ifc3 ();

  assign ifc0.SS    = ss[0];
  assign ifc0.SCLK  = p;
  assign ifc0.MOSI  = mosi;
  assign ifc0.DATAI = di[0];
  assign ifc0.WR    = wr[0];
  assign ifc3.SS    = ss[1];
  assign ifc3.SCLK  = ~p;
  assign ifc3.MOSI  = mosi;
  assign ifc3.DATAI = di[1];
  assign ifc3.WR    = wr[1];

  spi_slave #(.N(N), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (.CLOCK(clk), .RESET_N(rst_n), .bus(ifc0.slave));
  spi_slave #(.N(N), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (.CLOCK(clk), .RESET_N(rst_n), .bus(ifc3.slave));

  int n_vec = 0;
  int n_err = 0;

  int vcnt [2];
  always @(negedge clk) begin
    if (ifc0.VALID) vcnt[0] <= vcnt[0] + 1;
    if (ifc3.VALID) vcnt[1] <= vcnt[1] + 1;
  end

  // Word-level reference: one-deep buffer per device, consumed at every word start.
  logic       buf_full [2];
  logic [7:0] buf_m    [2];
  logic [7:0] exp_dato [2];

  typedef struct {
    int         dev;
    bit         pre;
    logic [7:0] pv;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_do;
  } vec_t;
  vec_t tbl [4];

  function automatic logic miso_of(input int d);
    return (d == 0) ? ifc0.MISO : ifc3.MISO;
  endfunction
  function automatic logic busy_of(input int d);
    return (d == 0) ? ifc0.BUSY : ifc3.BUSY;
  endfunction
  function automatic logic valid_of(input int d);
    return (d == 0) ? ifc0.VALID : ifc3.VALID;
  endfunction
  function automatic logic [7:0] dato_of(input int d);
    return (d == 0) ? ifc0.DATAO : ifc3.DATAO;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_wr(input int d, input logic [7:0] v);
    di[d] = v;
    wr[d] = 1'b1;
    cyc(1);
    wr[d] = 1'b0;
  endtask

  task automatic m_wr(input int d, input logic [7:0] v);
    if (!buf_full[d]) begin
      buf_full[d] = 1'b1;
      buf_m[d]    = v;
    end
    host_wr(d, v);
  endtask

  task automatic m_take(input int d, output logic [7:0] v);
    v = buf_full[d] ? buf_m[d] : 8'h00;
    buf_full[d] = 1'b0;
  endtask

  task automatic ss_low(input int d);
    ss[d] = 1'b0;
    cyc(H);
  endtask

  task automatic ss_high(input int d);
    cyc(H);
    ss[d] = 1'b1;
    cyc(H);
  endtask

  // Master side of one word (or its first nbits bits); dev 0 is mode 0, dev 1 is mode 3.
  task automatic word(input int d, input logic [7:0] mo, output logic [7:0] mi, input int nbits);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (d == 0) begin
        mosi = mo[i];
        cyc(H);
        p = 1'b1;
        mi[i] = miso_of(0);
        cyc(H);
        p = 1'b0;
      end else begin
        p = 1'b1;
        mosi = mo[i];
        cyc(H);
        p = 1'b0;
        mi[i] = miso_of(1);
        cyc(H);
      end
    end
  endtask

  task automatic frame(input int d, input int nw, input logic [23:0] mos, input int ab, input string tag);
    int         v0;
    logic [7:0] mi;
    logic [7:0] em;
    v0 = vcnt[d];
    ss_low(d);
    for (int k = 0; k < nw; k++) begin
      m_take(d, em);
      word(d, mos[8*k +: 8], mi, 8);
      check({tag, " miso"}, {24'h0, mi}, {24'h0, em});
      exp_dato[d] = mos[8*k +: 8];
      check({tag, " datao"}, {24'h0, dato_of(d)}, {24'h0, exp_dato[d]});
    end
    if (ab > 0) begin
      m_take(d, em);
      word(d, 8'h3F, mi, ab);
    end
    ss_high(d);
    cyc(4);
    check({tag, " valid count"}, 32'(vcnt[d] - v0), 32'(nw));
    check({tag, " datao end"}, {24'h0, dato_of(d)}, {24'h0, exp_dato[d]});
    check({tag, " busy"}, {31'h0, busy_of(d)}, {31'h0, buf_full[d]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    logic [7:0] em;
    int         v0;
    int         d;

    for (int i = 0; i < 2; i++) begin
      ss[i] = 1'b1; wr[i] = 1'b0; di[i] = 8'h00;
      buf_full[i] = 1'b0; buf_m[i] = 8'h00; exp_dato[i] = 8'h00; vcnt[i] = 0;
    end

    tbl[0] = '{dev: 0, pre: 1'b1, pv: 8'h3C, mo: 8'hA5, exp_mi: 8'h3C, exp_do: 8'hA5};
    tbl[1] = '{dev: 0, pre: 1'b0, pv: 8'h00, mo: 8'h81, exp_mi: 8'h00, exp_do: 8'h81};
    tbl[2] = '{dev: 1, pre: 1'b1, pv: 8'hC3, mo: 8'h96, exp_mi: 8'hC3, exp_do: 8'h96};
    tbl[3] = '{dev: 1, pre: 1'b0, pv: 8'h00, mo: 8'h3E, exp_mi: 8'h00, exp_do: 8'h3E};

    cyc(3);
    for (int i = 0; i < 2; i++) begin
      check("reset datao", {24'h0, dato_of(i)}, 32'h0);
      check("reset valid", {31'h0, valid_of(i)}, 32'h0);
      check("reset busy",  {31'h0, busy_of(i)},  32'h0);
      check("reset miso",  {31'h0, miso_of(i)},  32'h0);
    end
    rst_n = 1'b1;
    cyc(4);

    // Directed single-word table
    for (int i = 0; i < 4; i++) begin
      d  = tbl[i].dev;
      v0 = vcnt[d];
      if (tbl[i].pre) begin
        host_wr(d, tbl[i].pv);
        check("tbl busy after wr", {31'h0, busy_of(d)}, 32'h1);
      end
      ss_low(d);
      check("tbl busy after ss fall", {31'h0, busy_of(d)}, 32'h0);
      word(d, tbl[i].mo, mi, 8);
      check("tbl miso word", {24'h0, mi}, {24'h0, tbl[i].exp_mi});
      ss_high(d);
      cyc(4);
      check("tbl datao", {24'h0, dato_of(d)}, {24'h0, tbl[i].exp_do});
      check("tbl valid count", 32'(vcnt[d] - v0), 32'd1);
      exp_dato[d] = tbl[i].exp_do;
    end

    // Back-to-back words with SS held low; second WR lands once the first is consumed
    v0 = vcnt[0];
    m_wr(0, 8'h12);
    ss_low(0);
    check("b2b busy cleared", {31'h0, busy_of(0)}, 32'h0);
    m_take(0, em);
    m_wr(0, 8'h34);
    check("b2b busy second wr", {31'h0, busy_of(0)}, 32'h1);
    word(0, 8'h55, mi, 8);
    check("b2b miso w0", {24'h0, mi}, {24'h0, em});
    check("b2b datao w0", {24'h0, dato_of(0)}, 32'h55);
    m_take(0, em);
    word(0, 8'hAA, mi, 8);
    check("b2b miso w1", {24'h0, mi}, {24'h0, em});
    check("b2b datao w1", {24'h0, dato_of(0)}, 32'hAA);
    ss_high(0);
    cyc(4);
    check("b2b valid count", 32'(vcnt[0] - v0), 32'd2);
    check("b2b busy end", {31'h0, busy_of(0)}, 32'h0);
    exp_dato[0] = 8'hAA;

    // Abort after 3 bits, then a clean frame
    frame(0, 0, 24'h0, 3, "abort");
    frame(0, 1, 24'h00005A, 0, "after abort");

    // WR while BUSY is dropped
    m_wr(0, 8'h11);
    m_wr(0, 8'h22);
    check("busy wr held", {31'h0, busy_of(0)}, 32'h1);
    frame(0, 1, 24'h0000C7, 0, "busy wr first");
    frame(0, 1, 24'h000019, 0, "busy wr second");

    // Back-to-back and abort on the mode-3 instance
    m_wr(1, 8'hE7);
    frame(1, 2, 24'h00F00D, 5, "m3 b2b abort");

    // Random traffic
    for (int it = 0; it < 24; it++) begin
      int         nw;
      int         ab;
      logic [23:0] mos;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) m_wr(d, 8'($urandom));
      if ($urandom_range(0, 3) == 0) m_wr(d, 8'($urandom));
      check("rand busy", {31'h0, busy_of(d)}, {31'h0, buf_full[d]});
      nw  = int'($urandom_range(1, 3));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      mos = 24'($urandom);
      frame(d, nw, mos, ab, "rand");
    end

    // Reset mid-frame on mode 3, with a pending preload on mode 0
    m_wr(0, 8'h77);
    v0 = vcnt[1];
    ss_low(1);
    word(1, 8'hF0, mi, 3);
    rst_n = 1'b0;
    cyc(1);
    for (int i = 0; i < 2; i++) begin
      check("mid reset datao", {24'h0, dato_of(i)}, 32'h0);
      check("mid reset valid", {31'h0, valid_of(i)}, 32'h0);
      check("mid reset busy",  {31'h0, busy_of(i)},  32'h0);
      check("mid reset miso",  {31'h0, miso_of(i)},  32'h0);
      buf_full[i] = 1'b0;
      exp_dato[i] = 8'h00;
    end
    ss[1] = 1'b1;
    p = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(H);
    check("post reset no valid", 32'(vcnt[1] - v0), 32'd0);
    check("post reset datao", {24'h0, dato_of(1)}, 32'h0);
    frame(1, 1, 24'h000069, 0, "recover m3");
    frame(0, 1, 24'h0000B4, 0, "recover m0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
